// File: rtl/mipi_rx_pkg.sv
// Shared definitions for the MIPI HS receive path: FSM states and byte-level constants.
package mipi_rx_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SEARCH,
    ACTIVE,
    WAIT_EXIT
  } hsrx_state_e;

endpackage

// File: rtl/hs_bit_aligner.sv
// Serial-to-parallel shift register with sync-word compare and byte bit counter.
// Bits enter at the MSB so the first line bit ends up at bit 0 of a byte.
module hs_bit_aligner
  import mipi_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              shift_i,
  input  logic              count_i,
  input  logic              clear_i,
  input  logic              bit_i,
  output logic [BYTE_W-1:0] shift_d_o,
  output logic              match_o,
  output logic              byte_last_o
);

  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] shift_d;
  logic [2:0]        bitCnt_q;

  assign shift_d     = {bit_i, shift_q[BYTE_W-1:1]};
  assign shift_d_o   = shift_d;
  assign match_o     = (shift_d == SYNC_WORD);
  assign byte_last_o = (bitCnt_q == 3'd7);

  // Shift one line bit in per enabled edge, oldest bits moving toward bit 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else if (shift_i) begin
      shift_q <= shift_d;
    end
  end

  // Position of the next bit within the current byte; wraps naturally after bit 7.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitCnt_q <= '0;
    end else if (clear_i) begin
      bitCnt_q <= '0;
    end else if (count_i) begin
      bitCnt_q <= bitCnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/mipi_hsrx_ctrl.sv
// HS receive controller: settle wait, sync search with timeout, byte delivery
// and burst exit handling. All outputs are registered.
module mipi_hsrx_ctrl
  import mipi_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
  parameter int                SYNC_TIMEOUT = 32
) (
  input  logic              RxDDRClkHS,
  input  logic              RX_RST,
  input  logic              HS_REQ,
  input  logic [7:0]        SETTLE_CNT,
  input  logic              DRXHSP,
  output logic              HS_DESER_EN,
  output logic [BYTE_W-1:0] RxByteHS,
  output logic              RxValidHS,
  output logic              RxSyncHS,
  output logic              RxActiveHS,
  output logic              ErrSotSyncHS
);

  localparam int SEARCH_W = 16;

  hsrx_state_e         state_q;
  logic [7:0]          settleCnt_q;
  logic [7:0]          settleCnt_d;
  logic [SEARCH_W-1:0] searchCnt_q;
  logic [SEARCH_W-1:0] searchCnt_d;
  logic                deserEn_q;
  logic                active_q;
  logic                sync_q;
  logic                valid_q;
  logic                err_q;
  logic [BYTE_W-1:0]   byte_q;

  logic                sampleEn;
  logic                countEn;
  logic                matchRaw;
  logic                byteLast;
  logic                syncHit;
  logic                timeoutHit;
  logic                byteDone;
  logic [BYTE_W-1:0]   shiftNext;

  assign settleCnt_d = settleCnt_q + 8'd1;
  assign searchCnt_d = searchCnt_q + 16'd1;
  assign sampleEn    = (state_q == SEARCH) || (state_q == ACTIVE);
  assign countEn     = (state_q == ACTIVE);
  // A full byte must have been sampled in SEARCH before a match can count.
  assign syncHit     = (state_q == SEARCH) && HS_REQ && matchRaw &&
                       (searchCnt_q >= SEARCH_W'(BYTE_W - 1));
  assign timeoutHit  = ({16'd0, searchCnt_d} >= 32'(SYNC_TIMEOUT));
  // A byte completing on the exit edge is still delivered.
  assign byteDone    = countEn && byteLast;

  hs_bit_aligner #(
    .SYNC_WORD(SYNC_WORD)
  ) u_aligner (
    .clk_i      (RxDDRClkHS),
    .rst_i      (RX_RST),
    .shift_i    (sampleEn),
    .count_i    (countEn),
    .clear_i    (syncHit),
    .bit_i      (DRXHSP),
    .shift_d_o  (shiftNext),
    .match_o    (matchRaw),
    .byte_last_o(byteLast)
  );

  // Burst FSM with its counters and registered outputs; HS_REQ low always returns to IDLE.
  always_ff @(posedge RxDDRClkHS) begin
    if (RX_RST) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      searchCnt_q <= '0;
      deserEn_q   <= 1'b0;
      active_q    <= 1'b0;
      sync_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      byte_q      <= '0;
    end else begin
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (byteDone) begin
        byte_q  <= shiftNext;
        valid_q <= 1'b1;
      end
      if (!HS_REQ) begin
        state_q   <= IDLE;
        deserEn_q <= 1'b0;
        active_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= SETTLE;
            settleCnt_q <= '0;
          end
          SETTLE: begin
            if (settleCnt_q == SETTLE_CNT) begin
              state_q     <= SEARCH;
              searchCnt_q <= '0;
              deserEn_q   <= 1'b1;
            end else begin
              settleCnt_q <= settleCnt_d;
            end
          end
          SEARCH: begin
            if (syncHit) begin
              state_q  <= ACTIVE;
              sync_q   <= 1'b1;
              active_q <= 1'b1;
            end else if (timeoutHit) begin
              state_q   <= WAIT_EXIT;
              err_q     <= 1'b1;
              deserEn_q <= 1'b0;
            end else begin
              searchCnt_q <= searchCnt_d;
            end
          end
          ACTIVE: begin
            state_q <= ACTIVE;
          end
          WAIT_EXIT: begin
            state_q <= WAIT_EXIT;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign HS_DESER_EN  = deserEn_q;
  assign RxByteHS     = byte_q;
  assign RxValidHS    = valid_q;
  assign RxSyncHS     = sync_q;
  assign RxActiveHS   = active_q;
  assign ErrSotSyncHS = err_q;

endmodule

// File: tb/tb_mipi_hsrx_ctrl.sv
// Testbench for mipi_hsrx_ctrl: directed burst table, reset sequences and
// random bursts, all checked cycle by cycle against a burst-level model.
module tb_mipi_hsrx_ctrl;

  localparam int MAXT = 160;
  localparam int TO   = 32;

  typedef struct {
    int          settle;
    int          preLen;
    logic [15:0] preBits;
    bit          hasSync;
    int          nBytes;
    logic [23:0] bytes;
    int          dropBit;
    int          expSync;
    int          expValid;
    int          expErr;
    logic [7:0]  expLast;
  } vec_t;

  logic       clock = 1'b0;
  logic       rst;
  logic       hsReq;
  logic [7:0] settleCnt;
  logic       dIn;
  logic       deserEn;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxSync;
  logic       rxActive;
  logic       errSot;

  int total = 0;
  int bad   = 0;

  bit         dinArr[MAXT];
  bit         eDeser[MAXT];
  bit         eActive[MAXT];
  bit         eSync[MAXT];
  bit         eValid[MAXT];
  bit         eErr[MAXT];
  logic [7:0] eByte[MAXT];
  logic [7:0] carryByte;
  logic [7:0] syncWord = 8'hB8;
  int         nSync;
  int         nValid;
  int         nErr;
  vec_t       vecs[6];

  always #5 clock = ~clock;

  mipi_hsrx_ctrl #(
    .SYNC_WORD   (8'hB8),
    .SYNC_TIMEOUT(TO)
  ) dut (
    .RxDDRClkHS  (clock),
    .RX_RST      (rst),
    .HS_REQ      (hsReq),
    .SETTLE_CNT  (settleCnt),
    .DRXHSP      (dIn),
    .HS_DESER_EN (deserEn),
    .RxByteHS    (rxByte),
    .RxValidHS   (rxValid),
    .RxSyncHS    (rxSync),
    .RxActiveHS  (rxActive),
    .ErrSotSyncHS(errSot)
  );

  task automatic checkOutput(input string name, input int t, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Drive one edge's inputs on the falling edge, then wait until just after the rising edge.
  task automatic applyStimulus(input logic r, input logic h, input logic d);
    @(negedge clock);
    rst   = r;
    hsReq = h;
    dIn   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_deser"},  0, 8'(deserEn),  8'h00);
    checkOutput({tag, "_byte"},   0, rxByte,       8'h00);
    checkOutput({tag, "_valid"},  0, 8'(rxValid),  8'h00);
    checkOutput({tag, "_sync"},   0, 8'(rxSync),   8'h00);
    checkOutput({tag, "_active"}, 0, 8'(rxActive), 8'h00);
    checkOutput({tag, "_err"},    0, 8'(errSot),   8'h00);
  endtask

  // Burst-level expectations: edge 0 enters settle, first search bit is at edge settle+2,
  // sync is the first full-byte window equal to the sync word, bytes every 8 edges after it.
  task automatic buildModel(input int settle, input int lEdge, input int tLen);
    int s, e, es, et, lastDeser, endAct;
    logic [7:0] w, cur;
    s  = settle + 2;
    es = -1;
    et = -1;
    for (int t = 0; t < MAXT; t++) begin
      eDeser[t] = 0; eActive[t] = 0; eSync[t] = 0; eValid[t] = 0; eErr[t] = 0;
    end
    for (int j = 7; j < TO; j++) begin
      e = s + j;
      if (e >= lEdge || e >= tLen) break;
      for (int i = 0; i < 8; i++) w[i] = dinArr[e - 7 + i];
      if (w == syncWord) begin
        es = e;
        break;
      end
    end
    if (es < 0 && (s + TO - 1) < lEdge && (s + TO - 1) < tLen) et = s + TO - 1;
    if (et >= 0) lastDeser = et - 1;
    else lastDeser = lEdge - 1;
    if (lastDeser > tLen - 1) lastDeser = tLen - 1;
    for (int t = s - 1; t <= lastDeser; t++) eDeser[t] = 1;
    if (es >= 0) begin
      eSync[es] = 1;
      endAct = (lEdge < tLen) ? lEdge : tLen;
      for (int t = es; t < endAct; t++) eActive[t] = 1;
      for (int b = es + 8; b <= lEdge && b < tLen; b += 8) eValid[b] = 1;
    end
    if (et >= 0) eErr[et] = 1;
    cur = carryByte;
    for (int t = 0; t < tLen; t++) begin
      if (eValid[t]) for (int i = 0; i < 8; i++) cur[i] = dinArr[t - 7 + i];
      eByte[t] = cur;
    end
  endtask

  // Run one burst: HS_REQ high for edges below lEdge, checking every output every edge.
  task automatic runBurst(input int settle, input int lEdge, input int tLen);
    buildModel(settle, lEdge, tLen);
    settleCnt = 8'(settle);
    nSync = 0; nValid = 0; nErr = 0;
    for (int t = 0; t < tLen; t++) begin
      applyStimulus(1'b0, (t < lEdge), dinArr[t]);
      checkOutput("deser",  t, 8'(deserEn),  8'(eDeser[t]));
      checkOutput("active", t, 8'(rxActive), 8'(eActive[t]));
      checkOutput("sync",   t, 8'(rxSync),   8'(eSync[t]));
      checkOutput("valid",  t, 8'(rxValid),  8'(eValid[t]));
      checkOutput("err",    t, 8'(errSot),   8'(eErr[t]));
      checkOutput("byte",   t, rxByte,       eByte[t]);
      if (rxSync === 1'b1)  nSync++;
      if (rxValid === 1'b1) nValid++;
      if (errSot === 1'b1)  nErr++;
    end
    carryByte = eByte[tLen - 1];
  endtask

  // Lay out settle noise, prefix, sync word and data bytes on the line.
  task automatic buildStream(input vec_t v, input bit randFill, output int lEdge, output int tLen);
    int s, pos, dataStart;
    s = v.settle + 2;
    for (int t = 0; t < MAXT; t++)
      dinArr[t] = (t < s || randFill) ? ($urandom_range(0, 1) != 0) : 1'b0;
    pos = s;
    for (int i = 0; i < v.preLen; i++) begin
      dinArr[pos] = v.preBits[i];
      pos++;
    end
    if (v.hasSync) begin
      for (int i = 0; i < 8; i++) begin
        dinArr[pos] = syncWord[i];
        pos++;
      end
    end
    dataStart = pos;
    for (int k = 0; k < v.nBytes; k++) begin
      for (int i = 0; i < 8; i++) begin
        dinArr[pos] = v.bytes[8 * k + i];
        pos++;
      end
    end
    lEdge = dataStart + v.dropBit;
    tLen  = lEdge + 3;
  endtask

  initial begin
    int   lEdge, tLen;
    vec_t v;
    rst = 1'b1; hsReq = 1'b0; dIn = 1'b0; settleCnt = 8'd0; carryByte = 8'h00;

    vecs[0] = '{4, 0, 16'h0000, 1'b1, 2, 24'h00C35A, 16, 1, 2, 0, 8'hC3};
    vecs[1] = '{2, 3, 16'h0003, 1'b1, 1, 24'h00003C,  8, 1, 1, 0, 8'h3C};
    vecs[2] = '{3, 0, 16'h0000, 1'b0, 0, 24'h000000, 40, 0, 0, 1, 8'h3C};
    vecs[3] = '{1, 0, 16'h0000, 1'b1, 1, 24'h0000FF,  4, 1, 0, 0, 8'h3C};
    vecs[4] = '{0, 0, 16'h0000, 1'b1, 1, 24'h0000A5,  7, 1, 1, 0, 8'hA5};
    vecs[5] = '{7, 0, 16'h0000, 1'b1, 2, 24'h00FF00, 20, 1, 2, 0, 8'hFF};

    // Reset has priority even with HS_REQ high.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkAllZero("reset");
    end

    // Directed bursts with hand-derived pulse counts.
    for (int n = 0; n < 6; n++) begin
      buildStream(vecs[n], 1'b0, lEdge, tLen);
      runBurst(vecs[n].settle, lEdge, tLen);
      checkOutput("tally_sync",  n, 8'(nSync),  8'(vecs[n].expSync));
      checkOutput("tally_valid", n, 8'(nValid), 8'(vecs[n].expValid));
      checkOutput("tally_err",   n, 8'(nErr),   8'(vecs[n].expErr));
      checkOutput("tally_last",  n, rxByte,     vecs[n].expLast);
    end

    // Reset in the middle of an active burst, HS_REQ kept high throughout.
    v = '{2, 0, 16'h0000, 1'b1, 2, 24'h00E71B, 12, 1, 1, 0, 8'h1B};
    buildStream(v, 1'b1, lEdge, tLen);
    runBurst(v.settle, lEdge, lEdge);
    checkOutput("midrst_valid", 0, 8'(nValid), 8'd1);
    checkOutput("midrst_active", 0, 8'(rxActive), 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkAllZero("midrst");
    carryByte = 8'h00;
    v = '{1, 0, 16'h0000, 1'b1, 1, 24'h000096, 8, 1, 1, 0, 8'h96};
    buildStream(v, 1'b0, lEdge, tLen);
    runBurst(v.settle, lEdge, tLen);
    checkOutput("resync_sync",  0, 8'(nSync),  8'd1);
    checkOutput("resync_valid", 0, 8'(nValid), 8'd1);
    checkOutput("resync_byte",  0, rxByte,     8'h96);

    // Random bursts, including exits during settle and random search data.
    for (int n = 0; n < 25; n++) begin
      v.settle  = $urandom_range(0, 6);
      v.preLen  = $urandom_range(0, 12);
      v.preBits = 16'($urandom);
      v.hasSync = ($urandom_range(0, 4) != 0);
      v.nBytes  = $urandom_range(0, 3);
      v.bytes   = 24'($urandom);
      v.dropBit = v.hasSync ? $urandom_range(0, 8 * v.nBytes + 4) : $urandom_range(0, 40);
      buildStream(v, 1'b1, lEdge, tLen);
      if ($urandom_range(0, 7) == 0) lEdge = $urandom_range(1, v.settle + 2);
      if (lEdge + 3 < tLen) tLen = lEdge + 3;
      runBurst(v.settle, lEdge, tLen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
